ttt_move_ctrl: RTL
==================

# ttt_move_ctrl

Game-flow controller for the tic-tac-toe design, and the writer of the 18-bit board vector that the dot-matrix display reads. It consumes the raw 4-bit key code from the keypad scanner, debounces it into single press events, and runs the main/play/over state machine. It places X/O marks, alternates turns, detects wins and draws, and drives the mode flags used by the 7-segment logic.

## Interface
- DEB_CYCLES, 1000: consecutive clk rising edges a nonzero key code must be stable before one press event fires (range 1..65535).
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key_data  input  4  key code from the scanner:
  - 0: no key
  - 1..9: cells 1..9, row-major, cell 1 top-left
  - 10: '*'
  - 11: '0'
  - 12: '#'
  - 13..15: never driven, treated as 0
- board  output  18  two bits per cell; cell n at bits [2n-1:2n-2]. 00 empty, 01 X, 10 O, 11 never produced.
- is_main  output  1  1 while in MAIN
- turn_o  output  1  1 when O is to move; X always moves first
- game_over  output  1  1 while in OVER
- winner  output  2  00 none, 01 X, 10 O, 11 draw; valid while game_over=1, otherwise 00
- move_cnt  output  4  marks placed in the current game, 0..9
- illegal  output  1  one-cycle pulse: cell key pressed on an occupied cell in PLAY

## Operation
- Debouncer:
  - k_prev samples key_data every edge; a 16-bit cnt resets to 0 whenever key_data != k_prev, else saturating increment.
  - Internal press event pe fires for one cycle when cnt reaches DEB_CYCLES-1 with a nonzero code.
  - No further pe until the code changes, so holding a key yields exactly one event; release-then-repress yields a new one.
- State MAIN (reset state):
  - '#' -> PLAY: board=0, move_cnt=0, turn_o=0, winner=00.
  - All other keys ignored.
- State PLAY:
  - Cell key n on an empty cell:
    - Write 01 if turn_o=0, else 10.
    - move_cnt+1, toggle turn_o, -> CHECK.
  - Cell key on an occupied cell: illegal pulse; board, turn and count unchanged.
  - '*' -> MAIN with board cleared. '0' and '#' ignored.
- State CHECK (exactly one cycle; all events ignored):
  - Evaluate 8 lines: rows 123/456/789, columns 147/258/369, diagonals 159/357.
  - Any line all 01 -> winner=01, OVER.
  - Else any line all 10 -> winner=10, OVER.
  - Else move_cnt==9 -> winner=11, OVER.
  - Else -> PLAY.
  - Only the mover can complete a line, so a simultaneous X and O line cannot occur.
- State OVER:
  - Board frozen.
  - '#' -> PLAY with cleared board, turn X, move_cnt 0, winner 00.
  - '*' -> MAIN with cleared board.
  - Cell keys ignored; no illegal pulse.
- Outputs are registered. is_main and game_over decode the state registers directly; there is no combinational path from key_data.

## Timing
- Reset (async assert; deassert sampled on clk):
  - State MAIN, board=0, is_main=1, turn_o=0, game_over=0, winner=00, move_cnt=0, illegal=0.
  - Debounce cnt=0, k_prev=0.
- Reset mid-game or mid-debounce discards everything. A key still held after reset release must be re-debounced, then acts as a fresh press.
- Latency: key_data stable from edge E gives pe in the cycle after edge E+DEB_CYCLES-1. The action (board write, state change, illegal) is visible after edge E+DEB_CYCLES.
- Win/draw: game_over and winner are visible one edge after the board write (the CHECK cycle).
- A new pe arriving while in CHECK is dropped; no buffering.
- move_cnt never exceeds 9; OVER is entered no later than the 9th mark.

## Test plan
- Reset/start, DEB_CYCLES=4:
  - Reset -> is_main=1, board=0.
  - Hold 12 for 10 cycles -> is_main=0 exactly 5 edges after key applied; exactly one start, no repeat while held.
- X row win:
  - Presses 1,4,2,5,3, each followed by 0 -> board=18'b00_00_00_00_10_10_01_01_01.
  - game_over=1, winner=01, move_cnt=5.
  - Further cell keys ignored.
- Illegal move: in PLAY press 5 then 5 -> one illegal pulse on the second press; board cell5=01, turn_o=1, move_cnt=1.
- Draw: sequence 1,2,3,5,4,6,8,7,9 -> winner=11, game_over=1, move_cnt=9, no line complete.
- Restart/abort and bounce:
  - In OVER press 12 -> board=0, turn_o=0, winner=00.
  - In PLAY press 10 -> is_main=1, board=0.
  - Key toggling 3/0 every 2 cycles -> no event.
- Async reset mid-game: assert rst between edges after 3 moves -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe game-flow controller: debounces keypad codes into single press
// events, runs MAIN/PLAY/CHECK/OVER, and owns the 18-bit board seen by the display.
module ttt_move_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_data,
    output logic [17:0] board,
    output logic        is_main,
    output logic        turn_o,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_cnt,
    output logic        illegal
);

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    localparam logic [1:0] S_MAIN  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [3:0] K_STAR = 4'd10;
    localparam logic [3:0] K_HASH = 4'd12;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    logic [3:0]  key_clean;
    logic [3:0]  k_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pe;

    logic [1:0]  state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic        illegal_q, illegal_d;

    logic [8:0]  x_cell, o_cell, occ, sel;
    logic        is_cell, cell_occ, x_line, o_line;

    // Codes 13..15 are never driven by the scanner; fold them onto "no key".
    assign key_clean = (key_data > 4'd12) ? 4'd0 : key_data;

    always_comb begin
        cnt_d = cnt_q;
        if (key_clean != k_prev_q)
            cnt_d = 16'd0;
        else if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    // Saturating count crosses DEB_LAST once per stable code, so a held key fires once.
    assign pe = (cnt_q == DEB_LAST) && (k_prev_q != 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign x_cell[gi] = (board_q[2*gi +: 2] == MARK_X);
            assign o_cell[gi] = (board_q[2*gi +: 2] == MARK_O);
            assign occ[gi]    = (board_q[2*gi +: 2] != 2'b00);
            assign sel[gi]    = (k_prev_q == 4'(gi + 1));
        end
    endgenerate

    assign is_cell  = |sel;
    assign cell_occ = |(sel & occ);

    function automatic logic any_line(input logic [8:0] c);
        return (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
               (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
               (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    endfunction

    assign x_line = any_line(x_cell);
    assign o_line = any_line(o_cell);

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        move_cnt_d = move_cnt_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_MAIN: begin
                if (pe && k_prev_q == K_HASH) begin
                    state_d    = S_PLAY;
                    board_d    = '0;
                    turn_d     = 1'b0;
                    winner_d   = 2'b00;
                    move_cnt_d = 4'd0;
                end
            end
            S_PLAY: begin
                if (pe && is_cell) begin
                    if (cell_occ) begin
                        illegal_d = 1'b1;
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            if (sel[i])
                                board_d[2*i +: 2] = turn_q ? MARK_O : MARK_X;
                        end
                        move_cnt_d = move_cnt_q + 4'd1;
                        turn_d     = ~turn_q;
                        state_d    = S_CHECK;
                    end
                end else if (pe && k_prev_q == K_STAR) begin
                    state_d    = S_MAIN;
                    board_d    = '0;
                    turn_d     = 1'b0;
                    move_cnt_d = 4'd0;
                end
            end
            S_CHECK: begin
                // Only the player who just moved can have completed a line.
                if (x_line) begin
                    winner_d = MARK_X;
                    state_d  = S_OVER;
                end else if (o_line) begin
                    winner_d = MARK_O;
                    state_d  = S_OVER;
                end else if (move_cnt_q == 4'd9) begin
                    winner_d = 2'b11;
                    state_d  = S_OVER;
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                if (pe && (k_prev_q == K_HASH || k_prev_q == K_STAR)) begin
                    state_d    = (k_prev_q == K_HASH) ? S_PLAY : S_MAIN;
                    board_d    = '0;
                    turn_d     = 1'b0;
                    winner_d   = 2'b00;
                    move_cnt_d = 4'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_prev_q   <= 4'd0;
            cnt_q      <= 16'd0;
            state_q    <= S_MAIN;
            board_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            move_cnt_q <= 4'd0;
            illegal_q  <= 1'b0;
        end else begin
            k_prev_q   <= key_clean;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            move_cnt_q <= move_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    assign board     = board_q;
    assign is_main   = (state_q == S_MAIN);
    assign game_over = (state_q == S_OVER);
    assign turn_o    = turn_q;
    assign winner    = winner_q;
    assign move_cnt  = move_cnt_q;
    assign illegal   = illegal_q;

endmodule
